// File: rtl/match_count_display_pkg.sv
// Shared constants for the match counter display: digit count,
// seven-segment codes and digit-enable patterns.
package match_count_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int COUNT_W    = NUM_DIGITS * 4;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES  = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_HUNDS = 4'b1011;
  localparam logic [3:0] AN_THOUS = 4'b0111;

  function automatic logic [3:0] an_code(input logic [1:0] sel);
    logic [3:0] a;
    unique case (sel)
      2'd0:    a = AN_ONES;
      2'd1:    a = AN_TENS;
      2'd2:    a = AN_HUNDS;
      default: a = AN_THOUS;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/match_count_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder
// with a blank override.
module bcd_to_7seg
  import match_count_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/match_count_display.sv
// Counts registered match pulses in 4-digit BCD and drives a
// multiplexed active-low seven-segment display.
module match_count_display
  import match_count_display_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               z,
  input  logic               clear,
  output logic [COUNT_W-1:0] count_bcd,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam logic [REFRESH_BITS-1:0] REF_ONE = 1;

  logic                           r_z_q;
  logic [NUM_DIGITS-1:0][3:0]     r_count;
  logic [REFRESH_BITS-1:0]        r_refresh;
  logic [3:0]                     r_an;
  logic [6:0]                     r_seg;
  logic                           r_dp;

  logic [NUM_DIGITS-1:0][3:0]     w_count_inc;
  logic [1:0]                     w_sel;
  bcd_t                           w_digit;
  logic                           w_blank;
  logic [6:0]                     w_seg;

  // Decimal ripple increment; 9999 wraps to 0000.
  always_comb begin
    logic carry;
    carry       = 1'b1;
    w_count_inc = r_count;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r_count[i] == 4'd9) begin
          w_count_inc[i] = 4'd0;
        end else begin
          w_count_inc[i] = r_count[i] + 4'd1;
          carry          = 1'b0;
        end
      end
    end
  end

  assign w_sel   = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_digit = r_count[w_sel];

  // Blank only zeros above the highest nonzero digit.
  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LZ) begin
      unique case (w_sel)
        2'd0:    w_blank = 1'b0;
        2'd1:    w_blank = (r_count[3:1] == '0);
        2'd2:    w_blank = (r_count[3:2] == '0);
        default: w_blank = (r_count[3] == 4'd0);
      endcase
    end
  end

  bcd_to_7seg u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_z_q     <= 1'b0;
      r_count   <= '0;
      r_refresh <= '0;
      r_an      <= AN_ONES;
      r_seg     <= SEG_0;
      r_dp      <= 1'b1;
    end else begin
      r_z_q     <= z;
      r_refresh <= r_refresh + REF_ONE;
      r_an      <= an_code(w_sel);
      r_seg     <= w_seg;
      r_dp      <= 1'b1;
      if (clear) begin
        r_count <= '0;
      end else if (r_z_q) begin
        r_count <= w_count_inc;
      end
    end
  end

  assign count_bcd = r_count;
  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;

endmodule

// File: tb/tb_match_count_display.sv
// Directed vector bench for match_count_display with a
// 4-bit refresh counter.
module tb_match_count_display;

  logic        clk;
  logic        reset;
  logic        z;
  logic        clear;
  logic [15:0] count_bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_vec = 0;
  int n_bad = 0;

  match_count_display #(
    .REFRESH_BITS (4),
    .BLANK_LZ     (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .z         (z),
    .clear     (clear),
    .count_bcd (count_bcd),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        zz;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Clear, then feed n back-to-back pulses and let the pipeline drain.
  task automatic preload(input int n);
    z     = 1'b0;
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      z = 1'b1;
      step();
    end
    z = 1'b0;
    step();
    step();
  endtask

  logic [3:0] exp_an[4];
  logic [6:0] exp_sg[4];
  logic [3:0] prev_an;
  bit         found;

  initial begin
    vecs[0]  = '{clr: 1'b0, zz: 1'b1, exp: 16'h0000};
    vecs[1]  = '{clr: 1'b0, zz: 1'b1, exp: 16'h0001};
    vecs[2]  = '{clr: 1'b0, zz: 1'b1, exp: 16'h0002};
    vecs[3]  = '{clr: 1'b0, zz: 1'b0, exp: 16'h0003};
    vecs[4]  = '{clr: 1'b0, zz: 1'b0, exp: 16'h0003};
    vecs[5]  = '{clr: 1'b0, zz: 1'b1, exp: 16'h0003};
    vecs[6]  = '{clr: 1'b1, zz: 1'b0, exp: 16'h0000};
    vecs[7]  = '{clr: 1'b0, zz: 1'b0, exp: 16'h0000};
    vecs[8]  = '{clr: 1'b0, zz: 1'b1, exp: 16'h0000};
    vecs[9]  = '{clr: 1'b0, zz: 1'b0, exp: 16'h0001};
    vecs[10] = '{clr: 1'b0, zz: 1'b1, exp: 16'h0001};
    vecs[11] = '{clr: 1'b0, zz: 1'b0, exp: 16'h0002};

    exp_an[0] = 4'b1110; exp_sg[0] = 7'b0010010;
    exp_an[1] = 4'b1101; exp_sg[1] = 7'b1000000;
    exp_an[2] = 4'b1011; exp_sg[2] = 7'b1111001;
    exp_an[3] = 4'b0111; exp_sg[3] = 7'b1111111;

    reset = 1'b0;
    z     = 1'b0;
    clear = 1'b0;
    step();
    step();
    step();
    chk("rst_count", count_bcd, 16'h0000);
    chk("rst_an", 16'(an), 16'(4'b1110));
    chk("rst_seg", 16'(seg), 16'(7'b1000000));
    chk("rst_dp", 16'(dp), 16'h0001);
    reset = 1'b1;
    step();
    chk("rel_count", count_bcd, 16'h0000);
    chk("rel_an", 16'(an), 16'(4'b1110));
    chk("rel_seg", 16'(seg), 16'(7'b1000000));

    for (int i = 0; i < 12; i++) begin
      clear = vecs[i].clr;
      z     = vecs[i].zz;
      step();
      chk($sformatf("vec%0d", i), count_bcd, vecs[i].exp);
    end
    z     = 1'b0;
    clear = 1'b0;

    preload(99);
    chk("pre99", count_bcd, 16'h0099);
    z = 1'b1;
    step();
    z = 1'b0;
    chk("c99_hold", count_bcd, 16'h0099);
    step();
    chk("c99_to_100", count_bcd, 16'h0100);

    preload(9999);
    chk("pre9999", count_bcd, 16'h9999);
    z = 1'b1;
    step();
    z = 1'b0;
    step();
    chk("wrap", count_bcd, 16'h0000);

    preload(42);
    chk("pre42", count_bcd, 16'h0042);
    clear = 1'b1;
    z     = 1'b1;
    step();
    clear = 1'b0;
    z     = 1'b0;
    chk("clr42", count_bcd, 16'h0000);
    step();
    chk("clr42_next", count_bcd, 16'h0001);

    preload(6);
    z = 1'b1;
    step();
    step();
    chk("burst7", count_bcd, 16'h0007);
    reset = 1'b0;
    step();
    chk("mid_rst_count", count_bcd, 16'h0000);
    chk("mid_rst_an", 16'(an), 16'(4'b1110));
    chk("mid_rst_seg", 16'(seg), 16'(7'b1000000));
    chk("mid_rst_dp", 16'(dp), 16'h0001);
    reset = 1'b1;
    z     = 1'b0;
    step();
    chk("no_resid1", count_bcd, 16'h0000);
    step();
    chk("no_resid2", count_bcd, 16'h0000);

    preload(105);
    chk("pre105", count_bcd, 16'h0105);
    found   = 1'b0;
    prev_an = an;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
      else prev_an = an;
    end
    chk("scan_sync", 16'(found), 16'h0001);
    if (found) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("scan_an%0d", k), 16'(an), 16'(exp_an[k/4]));
        chk($sformatf("scan_seg%0d", k), 16'(seg), 16'(exp_sg[k/4]));
        chk($sformatf("scan_dp%0d", k), 16'(dp), 16'h0001);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/match_count_display.md
MATCH_COUNT_DISPLAY -- requirements
Module: match_count_display

Interface
REQ-001 Parameter REFRESH_BITS, default 18, sets the width of the display refresh counter; minimum 3.
REQ-002 Parameter BLANK_LZ, default 1; when 1, leading zeros are blanked.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-005 z  input  1  match pulse from the upstream 1101 sequence detector; high for one cycle per detected match.
REQ-006 clear  input  1  synchronous count clear, active-high.
REQ-007 count_bcd  output  16  registered 4-digit BCD match count {thousands, hundreds, tens, ones}.
REQ-008 an  output  4  digit enables, active-low; an[0] selects the ones digit.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low; held 1 (off).

Function
REQ-011 z SHALL be registered once (z_q) before use; no combinational path from z to any output.
REQ-012 Each cycle with z_q==1 SHALL increment count_bcd by exactly 1 on that edge; latency from z high to count change is 2 clk edges.
REQ-013 Back-to-back z high cycles SHALL each count; no edge detection.
REQ-014 Increment SHALL be decimal: a digit at 9 goes to 0 and carries into the next digit; every digit stays within 0-9.
REQ-015 At 9999, an increment SHALL wrap the count to 0000; there is no saturation and no overflow flag.
REQ-016 clear==1 SHALL set count_bcd to 0000 on that edge and take priority over a simultaneous z_q increment; that pulse is lost.
REQ-017 The free-running refresh counter SHALL be REFRESH_BITS wide and wrap modulo 2^REFRESH_BITS.
REQ-018 Its top two bits SHALL form the digit select: 0=ones/an=1110, 1=tens/1101, 2=hundreds/1011, 3=thousands/0111.
REQ-019 Exactly one an bit SHALL be low in every cycle after reset.
REQ-020 an, seg and dp SHALL be registered; seg SHALL match the digit shown by an in the same cycle.
REQ-021 Segment codes SHALL be active-low standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 With BLANK_LZ=1, a zero digit more significant than the highest nonzero digit SHALL show seg=1111111; the ones digit is never blanked.
REQ-023 The display SHALL scan continuously and SHALL NOT stall for counting or clearing.

Reset
REQ-024 Under reset==0 the block SHALL set z_q=0, count_bcd=0000, refresh counter=0, an=1110, seg=1000000 and dp=1.
REQ-025 Reset SHALL override clear and z, and SHALL take effect from any state, mid-scan or mid-carry.
REQ-026 The first count SHALL be possible on the second edge after reset deasserts.

Structure
REQ-027 A shared package/include SHALL hold the digit count (4), the ten segment codes, the blank code and the an select codes.
REQ-028 A sub-module bcd_to_7seg SHALL map a 4-bit BCD digit plus a blank flag to seg; it is combinational and instanced once.
REQ-029 The BCD counter, refresh counter and output registers SHALL live in match_count_display.

Verification (REFRESH_BITS=4 for simulation)
REQ-030 Hold reset=0 for 3 edges, then release -> count_bcd=0000, an=1110, seg=1000000, dp=1.
REQ-031 Drive z high for 3 consecutive cycles -> count_bcd steps 0001, 0002, 0003, with the first change 2 edges after z rises.
REQ-032 Preload count to 0099 via pulses, then pulse z once -> 0100; preload to 9999, then pulse z -> 0000.
REQ-033 Assert clear and z in the same cycle with count at 0042 -> 0000 after 1 edge; the following z pulse gives 0001.
REQ-034 With count 0105 and BLANK_LZ=1, observe a full scan -> ones/an=1110/seg=0010010, tens/an=1101/seg=1000000, hundreds/an=1011/seg=1111001, thousands/an=0111/seg=1111111; each digit held 4 cycles.
REQ-035 Assert reset=0 for one edge during a z burst at count 0007 -> next-edge outputs equal the REQ-024 values and there is no residual increment.
